// File: rtl/clock_display_sched.sv
// Display scheduler: snapshots sec/min/hr, converts them through one shared bin2bcd
// over three cycles, commits all six digits at once and scans them onto six anodes.
module clock_display_sched #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hr,
    input  logic       upd,
    output logic [5:0] conv_bin,
    input  logic [2:0] conv_tens,
    input  logic [3:0] conv_ones,
    output logic       busy,
    output logic [5:0] an,
    output logic [3:0] digit,
    output logic       dp_n
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CONV_S = 3'd1;
    localparam logic [2:0] CONV_M = 3'd2;
    localparam logic [2:0] CONV_H = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;

    logic [2:0]      state;
    logic            pending;
    logic [5:0]      snap_sec, snap_min, snap_hr;
    logic [5:0][3:0] shadow;
    logic [5:0][3:0] disp;
    logic [PW-1:0]   presc;
    logic [2:0]      idx;
    logic            blank;

    assign busy = (state != IDLE);

    always_comb begin
        conv_bin = 6'd0;
        case (state)
            CONV_S:  conv_bin = snap_sec;
            CONV_M:  conv_bin = snap_min;
            CONV_H:  conv_bin = snap_hr;
            default: conv_bin = 6'd0;
        endcase
    end

    // Conversion pass; display registers change only in COMMIT so fields never mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= 1'b0;
            snap_sec <= 6'd0;
            snap_min <= 6'd0;
            snap_hr  <= 6'd0;
            shadow   <= '0;
            disp     <= '0;
        end else begin
            if (busy && upd) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (upd || pending) begin
                        state    <= CONV_S;
                        snap_sec <= sec;
                        snap_min <= min;
                        snap_hr  <= hr;
                        pending  <= 1'b0;
                    end
                end
                CONV_S: begin
                    shadow[0] <= conv_ones;
                    shadow[1] <= {1'b0, conv_tens};
                    state     <= CONV_M;
                end
                CONV_M: begin
                    shadow[2] <= conv_ones;
                    shadow[3] <= {1'b0, conv_tens};
                    state     <= CONV_H;
                end
                CONV_H: begin
                    shadow[4] <= conv_ones;
                    shadow[5] <= {1'b0, conv_tens};
                    state     <= COMMIT;
                end
                COMMIT: begin
                    disp  <= shadow;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running scan prescaler, independent of conversion activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= 3'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign blank = LEAD_BLANK && (idx == 3'd5) && (disp[5] == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            an    <= 6'b111110;
            digit <= 4'd0;
            dp_n  <= 1'b1;
        end else begin
            an    <= blank ? 6'b111111 : ~(6'b000001 << idx);
            digit <= disp[idx];
            dp_n  <= !((idx == 3'd2) || (idx == 3'd4));
        end
    end

endmodule
